// File: rtl/iir_pkg.sv
// Shared types, tap indices and Q15.16 saturating arithmetic for the biquad MAC sequencer.
// The Q15.16 datapath is fixed at 32 bits (QW); the sequencer's DW must match it.
package iir_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StOut} state_e;

  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] A1 = 3'd3;
  localparam logic [2:0] A2 = 3'd4;
  localparam int N_TAPS = 5;

  localparam int unsigned QW = 32;
  localparam logic [QW-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [QW-1:0] Q_MIN = 32'h8000_0000;

  // acc +/- p in QW+1 bits; overflow shows as disagreeing top two bits.
  function automatic logic [QW-1:0] sat_addsub(input logic [QW-1:0] acc,
                                               input logic [QW-1:0] p,
                                               input logic sub,
                                               output logic sat);
    logic [QW:0] s;
    s = sub ? ({acc[QW-1], acc} - {p[QW-1], p}) : ({acc[QW-1], acc} + {p[QW-1], p});
    sat = (s[QW] != s[QW-1]);
    if (!sat) return s[QW-1:0];
    return s[QW] ? Q_MIN : Q_MAX;
  endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Five-entry biquad coefficient register file: one gated write port, one combinational read.
module iir_coef_bank
  import iir_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          en,
  input  logic [2:0]    addr,
  input  logic [DW-1:0] data,
  input  logic [2:0]    rd_idx,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] coef [N_TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) coef[i] <= '0;
    end else if (we && en && (addr <= A2)) begin
      coef[addr] <= data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_idx <= A2) rd_data = coef[rd_idx];
  end

endmodule

// File: rtl/iir_mac_sequencer.sv
// Direct-form-I biquad built around one shared external saturating multiplier:
// issues five products back to back and accumulates them as tagged results return.
module iir_mac_sequencer
  import iir_pkg::*;
#(
  parameter int unsigned DW      = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [DW-1:0] x_in,
  input  logic          x_valid,
  output logic          x_ready,
  output logic [DW-1:0] y_out,
  output logic          y_valid,
  input  logic          y_ready,
  output logic          y_sat,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic          cfg_busy,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  output logic          mul_start,
  input  logic [DW-1:0] mul_p,
  input  logic          mul_valid,
  output logic          err
);

  state_e        state;
  logic [2:0]    k_q;
  logic [2:0]    n_prod;
  logic          mul_sub;
  logic [DW-1:0] x0, x1, x2, y1, y2, acc;
  logic          tag_v [MUL_LAT];
  logic          tag_s [MUL_LAT];

  logic [2:0]    nxt_idx;
  logic [DW-1:0] nxt_data;
  logic [DW-1:0] coef_rd;
  logic [DW-1:0] acc_next;
  logic          acc_clamp;
  logic          tag_hit;
  logic          spurious;

  assign x_ready  = (state == StIdle);
  assign cfg_busy = (state != StIdle);

  iir_coef_bank #(
    .DW(DW)
  ) u_coef_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (cfg_we),
    .en     (state == StIdle),
    .addr   (cfg_addr),
    .data   (cfg_data),
    .rd_idx (nxt_idx),
    .rd_data(coef_rd)
  );

  // Operand pair for the next issue; in IDLE the first pair uses the incoming sample directly.
  always_comb begin
    nxt_idx  = (state == StIdle) ? B0 : k_q + 3'd1;
    nxt_data = '0;
    case (nxt_idx)
      B0:      nxt_data = x_in;
      B1:      nxt_data = x1;
      B2:      nxt_data = x2;
      A1:      nxt_data = y1;
      A2:      nxt_data = y2;
      default: nxt_data = '0;
    endcase
  end

  always_comb begin
    tag_hit  = mul_valid && tag_v[MUL_LAT-1];
    spurious = mul_valid && !tag_v[MUL_LAT-1];
    acc_clamp = 1'b0;
    acc_next = sat_addsub(acc, mul_p, tag_s[MUL_LAT-1], acc_clamp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      k_q       <= '0;
      n_prod    <= '0;
      mul_sub   <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      acc       <= '0;
      y_out     <= '0;
      y_valid   <= 1'b0;
      y_sat     <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_v[i] <= 1'b0;
        tag_s[i] <= 1'b0;
      end
    end else begin
      // Tag pipe mirrors the multiplier latency so each product finds its issue record.
      tag_v[0] <= mul_start;
      tag_s[0] <= mul_sub;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_s[i] <= tag_s[i-1];
      end
      if (spurious) err <= 1'b1;

      unique case (state)
        StIdle: begin
          if (clr) begin
            x1  <= '0;
            x2  <= '0;
            y1  <= '0;
            y2  <= '0;
            err <= 1'b0;
          end
          if (x_valid) begin
            x0        <= x_in;
            acc       <= '0;
            y_sat     <= 1'b0;
            n_prod    <= '0;
            k_q       <= '0;
            mul_start <= 1'b1;
            mul_a     <= nxt_data;
            mul_b     <= coef_rd;
            mul_sub   <= 1'b0;
            state     <= StIssue;
          end
        end
        StIssue, StDrain: begin
          if (state == StIssue) begin
            if (k_q == 3'(N_TAPS - 1)) begin
              mul_start <= 1'b0;
              mul_sub   <= 1'b0;
              state     <= StDrain;
            end else begin
              k_q     <= k_q + 3'd1;
              mul_a   <= nxt_data;
              mul_b   <= coef_rd;
              mul_sub <= (nxt_idx >= A1);
            end
          end
          if (tag_hit) begin
            acc    <= acc_next;
            n_prod <= n_prod + 3'd1;
            if (acc_clamp) y_sat <= 1'b1;
            if (n_prod == 3'(N_TAPS - 1)) begin
              y_out   <= acc_next;
              y_valid <= 1'b1;
              x2      <= x1;
              x1      <= x0;
              y2      <= y1;
              y1      <= acc_next;
              state   <= StOut;
            end
          end
        end
        StOut: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_mac_sequencer.sv
// Self-checking bench: directed biquad scenarios plus randomized samples against a
// behavioural filter model and a two-stage saturating multiplier model.
module tb_iir_mac_sequencer;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr, x_valid, y_ready, cfg_we;
  logic [31:0] x_in, cfg_data;
  logic [2:0]  cfg_addr;
  logic        x_ready, y_valid, y_sat, cfg_busy, mul_start, mul_valid, err;
  logic [31:0] y_out, mul_a, mul_b, mul_p;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] got_y;
  logic        got_s;
  logic [31:0] m_coef [5];
  logic [31:0] mx1, mx2, my1, my2;

  always #5 clk = ~clk;

  iir_mac_sequencer #(
    .DW     (32),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .x_in     (x_in),
    .x_valid  (x_valid),
    .x_ready  (x_ready),
    .y_out    (y_out),
    .y_valid  (y_valid),
    .y_ready  (y_ready),
    .y_sat    (y_sat),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_busy (cfg_busy),
    .mul_a    (mul_a),
    .mul_b    (mul_b),
    .mul_start(mul_start),
    .mul_p    (mul_p),
    .mul_valid(mul_valid),
    .err      (err)
  );

  // Q15.16 product, floor-truncated and saturated to 32 bits.
  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = (longint'($signed(a)) * longint'($signed(b))) >>> 16;
    if (p > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (p < -64'sh8000_0000) return 32'h8000_0000;
    return p[31:0];
  endfunction

  // External multiplier: fixed two-cycle pipeline, plus an injection hook for stray results.
  logic [1:0]  pv = 2'b00;
  logic [31:0] pp0, pp1;
  logic        inj = 1'b0;
  always @(posedge clk) begin
    pv  <= {pv[0], mul_start};
    pp0 <= qmul(mul_a, mul_b);
    pp1 <= pp0;
  end
  assign mul_valid = pv[1] | inj;
  assign mul_p     = pp1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_coef[i] = '0;
    mx1 = '0; mx2 = '0; my1 = '0; my2 = '0;
  endtask

  task automatic model_step(input logic [31:0] x, input logic with_clr,
                            output logic [31:0] y, output logic s);
    logic [31:0] d [5];
    longint acc, t;
    if (with_clr) begin
      mx1 = '0; mx2 = '0; my1 = '0; my2 = '0;
    end
    d[0] = x; d[1] = mx1; d[2] = mx2; d[3] = my1; d[4] = my2;
    acc = 0;
    s = 1'b0;
    for (int k = 0; k < 5; k++) begin
      t = longint'($signed(qmul(d[k], m_coef[k])));
      acc = (k < 3) ? acc + t : acc - t;
      if (acc > 64'sh7FFF_FFFF) begin
        acc = 64'sh7FFF_FFFF; s = 1'b1;
      end else if (acc < -64'sh8000_0000) begin
        acc = -64'sh8000_0000; s = 1'b1;
      end
    end
    y = acc[31:0];
    mx2 = mx1; mx1 = x; my2 = my1; my1 = y;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (a <= 3'd4) m_coef[a] = d;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mx1 = '0; mx2 = '0; my1 = '0; my2 = '0;
  endtask

  // Push one sample through, check timing/handshake, and compare against the model.
  task automatic apply(input logic [31:0] x, input int hold, input logic bad_cfg,
                       input logic with_clr);
    logic [63:0] smask, vmask;
    logic [31:0] exp_y, y0;
    logic        exp_s, s0, stable;
    int n;
    n = 0;
    while (!x_ready && n < 50) begin
      tick(); n++;
    end
    check("x_ready_idle", x_ready, 1);
    x_in = x; x_valid = 1'b1; clr = with_clr;
    tick();
    x_valid = 1'b0; clr = 1'b0;
    model_step(x, with_clr, exp_y, exp_s);
    smask = '0; vmask = '0;
    n = 1;
    while (!y_valid && n < 40) begin
      if (mul_start) smask[n] = 1'b1;
      if (mul_valid) vmask[n] = 1'b1;
      if (bad_cfg && n == 1) begin
        check("cfg_busy_issue", cfg_busy, 1);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 32'h1234_5678;
      end
      tick();
      cfg_we = 1'b0;
      n++;
    end
    check("y_valid_seen", y_valid, 1);
    check("latency", n, 6 + MUL_LAT);
    check("mul_start_cycles", smask[31:0], 32'h0000_003E);
    check("mul_valid_cycles", vmask[31:0], 32'h0000_00F8);
    y0 = y_out; s0 = y_sat; stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (y_out !== y0 || y_sat !== s0 || x_ready !== 1'b0 || y_valid !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", stable, 1);
    got_y = y_out; got_s = y_sat;
    check("y_vs_model", got_y, exp_y);
    check("sat_vs_model", got_s, exp_s);
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    check("y_valid_drop", y_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] xr;
    clr = 0; x_valid = 0; y_ready = 0; cfg_we = 0; x_in = 0; cfg_data = 0; cfg_addr = 0;
    model_reset();
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    check("rst_x_ready", x_ready, 1);
    check("rst_y_valid", y_valid, 0);
    check("rst_y_out", y_out, 0);
    check("rst_y_sat", y_sat, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_err", err, 0);
    check("rst_cfg_busy", cfg_busy, 0);

    // Identity
    cfg_write(3'd0, 32'h0001_0000);
    apply(32'h0003_0000, 0, 1'b0, 1'b0);
    check("ident_y", got_y, 32'h0003_0000);
    check("ident_sat", got_s, 0);
    check("ident_err", err, 0);

    // Pure delay
    do_clr();
    cfg_write(3'd0, 32'h0);
    cfg_write(3'd1, 32'h0001_0000);
    apply(32'h0005_0000, 0, 1'b0, 1'b0);
    check("delay_y0", got_y, 32'h0);
    apply(32'h0007_0000, 0, 1'b0, 1'b0);
    check("delay_y1", got_y, 32'h0005_0000);

    // Feedback impulse response
    do_clr();
    cfg_write(3'd0, 32'h0001_0000);
    cfg_write(3'd1, 32'h0);
    cfg_write(3'd3, 32'h0000_8000);
    apply(32'h0001_0000, 0, 1'b0, 1'b0);
    check("fb_y0", got_y, 32'h0001_0000);
    apply(32'h0, 0, 1'b0, 1'b0);
    check("fb_y1", got_y, 32'hFFFF_8000);
    apply(32'h0, 0, 1'b0, 1'b0);
    check("fb_y2", got_y, 32'h0000_4000);
    apply(32'h0, 0, 1'b0, 1'b0);
    check("fb_y3", got_y, 32'hFFFF_E000);

    // Saturation, then clr restores a clean history
    do_clr();
    cfg_write(3'd3, 32'h0);
    cfg_write(3'd1, 32'h0001_0000);
    cfg_write(3'd5, 32'h5555_5555);
    apply(32'h7FFF_0000, 0, 1'b0, 1'b0);
    apply(32'h7FFF_0000, 0, 1'b0, 1'b0);
    check("sat_y", got_y, 32'h7FFF_FFFF);
    check("sat_flag", got_s, 1);
    do_clr();
    apply(32'h0001_0000, 0, 1'b0, 1'b0);
    check("post_clr_y", got_y, 32'h0001_0000);
    check("post_clr_sat", got_s, 0);

    // Backpressure hold and dropped cfg write during ISSUE; next sample proves b0 unchanged
    apply(32'h0002_0000, 10, 1'b1, 1'b0);
    apply(32'h0004_0000, 0, 1'b0, 1'b0);
    check("cfg_dropped_y", got_y, 32'h0006_0000);

    // Stray product in IDLE flags err; clr clears it
    inj = 1'b1;
    tick();
    inj = 1'b0;
    check("spurious_err", err, 1);
    do_clr();
    check("clr_err", err, 0);

    // Reset while in DRAIN
    x_in = 32'h0003_0000; x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    repeat (5) tick();
    check("drain_busy", cfg_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("amid_x_ready", x_ready, 1);
    check("amid_y_valid", y_valid, 0);
    check("amid_mul_start", mul_start, 0);
    check("amid_mul_a", mul_a, 0);
    check("amid_mul_b", mul_b, 0);
    check("amid_cfg_busy", cfg_busy, 0);
    check("amid_y_out", y_out, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    tick();
    apply(32'h0005_0000, 0, 1'b0, 1'b0);
    check("post_rst_y", got_y, 32'h0);
    check("post_rst_err", err, 0);

    // Randomized samples, coefficients and hold times
    for (int i = 0; i < 24; i++) begin
      if (i == 0 || i == 12) begin
        for (int c = 0; c < 5; c++) cfg_write(3'(c), 32'($signed($urandom) >>> 14));
      end
      xr = (i % 5 == 0) ? $urandom : 32'($signed($urandom) >>> 10);
      apply(xr, $urandom_range(0, 3), 1'b0, ($urandom_range(0, 5) == 0));
    end
    check("rand_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iir_mac_sequencer.md
Name: iir_mac_sequencer

Overview:
- Sequences one shared saturating fixed-point multiplier to compute a direct-form-I biquad: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
- The multiplier is an external fixed-latency pipeline that ends in the saturating output selector and produces Q15.16 products.
- Sits between the sample stream and the multiplier. It owns the coefficient bank, the delay line, the saturating accumulator and both stream handshakes.

Parameters:
- DW, 32, sample/coefficient/product width, signed Q15.16.
- MUL_LAT, 2, cycles from mul_start to matching mul_valid (≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  sync: zero delay line, clear err
- x_in  in  DW  input sample
- x_valid  in  1  sample offered
- x_ready  out  1  sample accepted when x_valid&&x_ready
- y_out  out  DW  filtered sample
- y_valid  out  1  y_out valid
- y_ready  in  1  consumer accepts
- y_sat  out  1  accumulator clamped during this sample
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  3  0=b0,1=b1,2=b2,3=a1,4=a2; 5–7 ignored
- cfg_data  in  DW  coefficient value
- cfg_busy  out  1  high outside IDLE; writes dropped
- mul_a  out  DW  multiplier operand (data)
- mul_b  out  DW  multiplier operand (coefficient)
- mul_start  out  1  issue one product
- mul_p  in  DW  saturated product
- mul_valid  in  1  mul_p valid
- err  out  1  sticky: mul_valid outside a pending product

Behaviour:
- Reset (rst_n low, async): state IDLE; x_ready=1; y_valid=0; y_out=0; y_sat=0; mul_start=0; mul_a=0; mul_b=0; err=0; cfg_busy=0; coefficients, x1, x2, y1, y2 and accumulator all 0. Reset mid-sample abandons the sample. Products returning after reset deassertion count as unexpected (err).
- FSM IDLE → ISSUE → DRAIN → OUT → IDLE.
- IDLE:
  - x_ready=1.
  - On x_valid: latch x_in, clear accumulator and y_sat, go ISSUE.
  - cfg_we with cfg_addr≤4 writes the coefficient here only.
- ISSUE:
  - 5 consecutive cycles, index k=0..4, mul_start=1.
  - Operand pairs (mul_a,mul_b) in order: (x,b0),(x1,b1),(x2,b2),(y1,a1),(y2,a2).
  - A tag shift register of depth MUL_LAT carries "valid, subtract" per issue; subtract=1 for k=3,4.
  - Then go DRAIN.
- Accumulate on every mul_valid with a matching tag: acc ± mul_p. Computed in DW+1 bits, clamped to 0x7FFFFFFF/0x80000000. A clamp sets y_sat.
- DRAIN: after the 5th product is accumulated, go OUT.
- OUT entry (same edge as the 5th accumulate):
  - y_out=saturated acc, y_valid=1.
  - Delay-line shift: x2←x1, x1←x, y2←y1, y1←y.
  - y_out and y_sat held stable until y_ready. On y_valid&&y_ready: y_valid=0, go IDLE.
- Latency (MUL_LAT=2):
  - Accept edge = cycle 0.
  - mul_start high in cycles 1–5; mul_valid in cycles 3–7; y_valid rises in cycle 8.
  - Generally y_valid rises at cycle 6+MUL_LAT.
  - Minimum initiation interval is 7+MUL_LAT cycles (includes the IDLE cycle).
- Backpressure: x_ready=0 in ISSUE/DRAIN/OUT; no sample is buffered.
- clr:
  - Honoured in IDLE only; ignored in other states.
  - Zeroes x1, x2, y1, y2 and err; coefficients kept.
  - clr and x_valid in the same IDLE cycle: clear first, then accept; the accepted sample sees a zero history.
- mul_valid with an empty tag slot: product ignored, err=1.
- Missing mul_valid is not detected; the FSM waits in DRAIN.

Decomposition:
- Package iir_pkg:
  - state enum (IDLE, ISSUE, DRAIN, OUT)
  - coefficient index constants (B0..A2, N_TAPS=5)
  - Q15.16 MAX/MIN constants
  - saturating add/sub function
- Sub-module iir_coef_bank: 5×DW register file with write port (we, addr, data, enable=idle) and one combinational read by index.

Test Plan:
- Identity: b0=0x00010000, others 0; x=0x00030000 → y=0x00030000, y_sat=0. Exact mul_start/mul_valid/y_valid cycle timing checked against a MUL_LAT=2 multiplier model.
- Pure delay: b1=0x00010000, others 0; x sequence 0x00050000, 0x00070000 → y sequence 0, 0x00050000.
- Feedback:
  - Setup: b0=0x00010000, a1=0x00008000 (0.5).
  - Stimulus: impulse x=0x00010000, then zeros.
  - Required y: 0x00010000, 0xFFFF8000, 0x00004000, 0xFFFFE000.
- Saturation: b0=b1=0x00010000; x=0x7FFF0000 twice → second y=0x7FFFFFFF, y_sat=1. Then clr and x=0x00010000 → y=0x00010000, y_sat=0.
- Handshake/config: hold y_ready=0 for 10 cycles → y_out stable and x_ready=0. cfg_we during ISSUE is dropped and cfg_busy=1. Spurious mul_valid in IDLE → err=1, which clr clears.
- Reset mid-operation: assert rst_n low during DRAIN → all outputs at reset values immediately. The next sample after release uses zero coefficients → y=0.
